// File: rtl/reg_file_wb_pkg.sv
// Shared types and sizing for the writeback-side register file and its
// pending-write scoreboard.
package reg_file_wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam addr_t REG_ZERO = '0;
  localparam cnt_t  CNT_MAX  = '1;

endpackage

// File: rtl/reg_file_wb_if.sv
// Writeback, decode-read and issue signals of the register file, bundled.
// The master side is the pipeline (decode + writeback); the slave side is
// the register file.
interface reg_file_wb_if;
  import reg_file_wb_pkg::*;

  // Writeback port
  logic  regShouldWrite_in;
  addr_t regWriteAddress_in;
  data_t regWriteData_in;

  // Decode read ports
  addr_t readAddrA_in;
  addr_t readAddrB_in;
  data_t readDataA_out;
  data_t readDataB_out;

  // Decode issue / hazard
  logic  issueValid_in;
  logic  issueWrites_in;
  addr_t issueDest_in;
  logic  useA_in;
  logic  useB_in;
  logic  stall_out;
  logic  pendingOverflow_out;

  modport master (
    output regShouldWrite_in, regWriteAddress_in, regWriteData_in,
    output readAddrA_in, readAddrB_in,
    output issueValid_in, issueWrites_in, issueDest_in, useA_in, useB_in,
    input  readDataA_out, readDataB_out, stall_out, pendingOverflow_out
  );

  modport slave (
    input  regShouldWrite_in, regWriteAddress_in, regWriteData_in,
    input  readAddrA_in, readAddrB_in,
    input  issueValid_in, issueWrites_in, issueDest_in, useA_in, useB_in,
    output readDataA_out, readDataB_out, stall_out, pendingOverflow_out
  );

endinterface

// File: rtl/reg_file_wb_scoreboard.sv
// Pending-write scoreboard: one saturating counter per architectural
// register, a sticky over/underflow flag, and RAW-hazard stall generation.
// Optional macro: REGFILE_BYPASS_EN -- a retire of the last outstanding
// write in the same cycle counts as cleared for the stall.
module reg_scoreboard
  import reg_file_wb_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  issue_valid_i,
  input  logic  issue_writes_i,
  input  addr_t issue_dest_i,
  input  logic  retire_i,
  input  addr_t retire_addr_i,
  input  logic  use_a_i,
  input  addr_t addr_a_i,
  input  logic  use_b_i,
  input  addr_t addr_b_i,
  output logic  stall_o,
  output logic  ovf_o
);

  cnt_t cnt_q [NUM_REGS];
  cnt_t cnt_d [NUM_REGS];
  logic ovf_q, ovf_d;
  logic pend_a, pend_b;
  logic issue_fire;

  // Hazard detection: a used source with any outstanding writer stalls decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pend_a = (cnt_q[addr_a_i] != '0);
    pend_b = (cnt_q[addr_b_i] != '0);
`ifdef REGFILE_BYPASS_EN
    // The last writer retiring this cycle is forwarded, so it no longer blocks.
    if (retire_i && retire_addr_i == addr_a_i && addr_a_i != REG_ZERO &&
        cnt_q[addr_a_i] == cnt_t'(1)) pend_a = 1'b0;
    if (retire_i && retire_addr_i == addr_b_i && addr_b_i != REG_ZERO &&
        cnt_q[addr_b_i] == cnt_t'(1)) pend_b = 1'b0;
`endif
    stall_o = (use_a_i & pend_a) | (use_b_i & pend_b);
  end

  // A stalled issue does not enter the pipeline, so it must not count.
  assign issue_fire = issue_valid_i & ~stall_o & issue_writes_i;

  // Counter next state: +1 on issue, -1 on retire, saturating with error flag.
  always_comb begin
    logic inc, dec;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    inc   = 1'b0;
    dec   = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc = issue_fire && (issue_dest_i == addr_t'(r));
      dec = retire_i && (retire_addr_i == addr_t'(r));
      if (inc && !dec) begin
        if (cnt_q[r] == CNT_MAX) ovf_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + cnt_t'(1);
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) ovf_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - cnt_t'(1);
      end
    end
    // Register 0 never has a pending writer.
    cnt_d[0] = '0;
  end

  // Counter and flag state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      cnt_q <= '{default: '0};
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file at the writeback end of the pipeline:
// 32 x 32-bit storage, one write port, two combinational read ports, plus
// the pending-write scoreboard that stalls decode on RAW hazards.
// Optional macro: REGFILE_BYPASS_EN -- write-through forwarding from the
// writeback port to the read ports in the same cycle.
module reg_file_wb
  import reg_file_wb_pkg::*;
(
  input  logic         CLK,
  input  logic         Reset_in,
  reg_file_wb_if.slave bus
);

  data_t regs_q [NUM_REGS];
  data_t rd_a, rd_b;
  logic  wr_en;

  assign wr_en = bus.regShouldWrite_in && (bus.regWriteAddress_in != REG_ZERO);

  // Register storage; writes to r0 are dropped.
  always_ff @(posedge CLK) begin
    // NOTE: the array is flops, not a RAM macro, so it can and must clear on reset.
    if (Reset_in)   regs_q <= '{default: '0};
    else if (wr_en) regs_q[bus.regWriteAddress_in] <= bus.regWriteData_in;
  end

  // Read muxes: r0 reads zero; optional same-cycle forwarding of writeback data.
  always_comb begin
    rd_a = (bus.readAddrA_in == REG_ZERO) ? '0 : regs_q[bus.readAddrA_in];
    rd_b = (bus.readAddrB_in == REG_ZERO) ? '0 : regs_q[bus.readAddrB_in];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && bus.regWriteAddress_in == bus.readAddrA_in) rd_a = bus.regWriteData_in;
    if (wr_en && bus.regWriteAddress_in == bus.readAddrB_in) rd_b = bus.regWriteData_in;
`endif
  end

  assign bus.readDataA_out = rd_a;
  assign bus.readDataB_out = rd_b;

  reg_scoreboard u_scoreboard (
    .clk_i          (CLK),
    .rst_i          (Reset_in),
    .issue_valid_i  (bus.issueValid_in),
    .issue_writes_i (bus.issueWrites_in),
    .issue_dest_i   (bus.issueDest_in),
    .retire_i       (bus.regShouldWrite_in),
    .retire_addr_i  (bus.regWriteAddress_in),
    .use_a_i        (bus.useA_in),
    .addr_a_i       (bus.readAddrA_in),
    .use_b_i        (bus.useB_in),
    .addr_b_i       (bus.readAddrB_in),
    .stall_o        (bus.stall_out),
    .ovf_o          (bus.pendingOverflow_out)
  );

endmodule
